sliding_window_buffer: RTL and testbench
========================================

# sliding_window_buffer

Parametrised streaming window generator that replaces the hard-wired 3-row cascading buffers ahead of the Sobel and connected-components stages. It accepts one raster-order pixel per valid cycle and keeps KERNEL-1 full line buffers. Each accepted pixel produces a registered KERNEL×KERNEL window anchored at that pixel, together with the pixel's coordinates. Pixels are not shifted while input is stalled.

## Interface
- PIXEL_WIDTH, 8, bits per pixel
- FRAME_WIDTH, 550, pixels per row; legal range KERNEL..4095
- KERNEL, 3, window side length; legal range 2..7
- COORD_WIDTH, 16, width of the row and column coordinate outputs
- clk  input  1  single clock; all logic is rising-edge
- reset  input  1  asynchronous, active-high; clears all control state and outputs
- in_valid  input  1  in_data is a pixel to accept this cycle
- in_sof  input  1  start of frame; qualified by in_valid; the accompanying pixel is (row 0, col 0)
- in_data  input  PIXEL_WIDTH  pixel value
- out_valid  output  1  out_window, out_row, out_col, out_sof and out_eol are valid
- out_window  output  KERNEL*KERNEL*PIXEL_WIDTH  flattened window, described under Operation
- out_row  output  COORD_WIDTH  row of the anchor (newest) pixel
- out_col  output  COORD_WIDTH  column of the anchor pixel
- out_sof  output  1  anchor pixel is (0,0)
- out_eol  output  1  anchor pixel is in column FRAME_WIDTH-1

## Operation
- State:
  - col counter, 0..FRAME_WIDTH-1
  - row counter, saturating at 2^COORD_WIDTH-1
  - KERNEL-1 line buffers of FRAME_WIDTH entries each
  - a KERNEL×KERNEL register window
- On an accepted pixel (in_valid=1):
  - the pixel is shifted into the bottom window row;
  - the pixel leaving each buffer feeds the window row above and the next buffer;
  - the counters advance.
- Column wrap: at col=FRAME_WIDTH-1, col becomes 0 and row increments.
- in_sof=1 with in_valid=1: this pixel is (0,0) regardless of the counters, and the next pixel is (0,1).
- in_sof while in_valid=0 is ignored.
- Frames may be restarted by in_sof at any point. Line-buffer contents are not cleared.
- Window layout: slice index i=r*KERNEL+c (r,c in 0..KERNEL-1) holds the pixel at (row-(KERNEL-1-r), col-(KERNEL-1-c)).
  - Index KERNEL*KERNEL-1 is the anchor pixel.
  - Index 0 is the top-left pixel.
  - For KERNEL=3 this matches Sobel p1..p9.
- Taps that fall outside the frame (negative row or column offset) are handled per Configuration.
- Line buffers and window data registers are not reset; only counters, flags and outputs are reset.
- All arithmetic is unsigned. No pixel data is modified.

## Timing
- Latency is 1 cycle: a pixel accepted at edge N appears on the outputs after edge N, together with its coordinates.
- No backpressure: the block is always ready.
- in_valid=0 cycles:
  - out_valid=0 on the following cycle;
  - out_window, out_row and out_col hold;
  - no buffer shifts.
- Reset (asynchronous assert, synchronous use after release):
  - out_valid, out_sof and out_eol are 0;
  - out_window, out_row and out_col are 0;
  - the counters are (0,0), so the first pixel after reset is treated as (0,0) even without in_sof.
- Reset asserted mid-frame: the outputs clear immediately and the partial frame is abandoned.
- Row counter saturation: out_row stays at its maximum value and columns keep wrapping.

## Configuration
- WINDOW_ZERO_PAD_EN defined:
  - out_valid=1 for every accepted pixel;
  - out-of-frame taps are forced to 0 rather than showing stale buffer or previous-row data;
  - the number of windows emitted equals the number of pixels in the frame.
- WINDOW_ZERO_PAD_EN undefined:
  - out_valid=1 only when row≥KERNEL-1 and col≥KERNEL-1, so only fully interior windows are emitted;
  - out-of-frame taps are never presented as valid;
  - there is no masking logic.

## Test plan
All scenarios use FRAME_WIDTH=4, KERNEL=3, PIXEL_WIDTH=8 and a 4×4 frame with pixel value row*4+col+1. Values are listed from slice 0 to slice 8.
- Interior only (no macro), ramp with in_sof on the first pixel:
  - exactly 4 out_valid pulses, at anchors (2,2), (2,3), (3,2), (3,3);
  - the first window is 1,2,3,5,6,7,9,10,11 and the last is 6,7,8,10,11,12,14,15,16.
- Zero pad (WINDOW_ZERO_PAD_EN), same stimulus:
  - 16 out_valid pulses;
  - anchor (0,0) gives 0,0,0,0,0,0,0,0,1 with out_sof=1;
  - anchor (1,0) gives 0,0,0,0,0,1,0,0,5;
  - anchor (0,3) gives out_eol=1.
- Stall: insert 3 idle cycles between each pixel of the ramp:
  - out_valid is high exactly 1 cycle per accepted pixel;
  - windows are identical to the first scenario;
  - outputs hold during idle cycles.
- Frame restart: send 6 pixels, then assert in_sof with value 100:
  - the next output has out_row=0, out_col=0 and out_sof=1;
  - zero-pad mode: the window is 0,…,0,100.
- Async reset: assert reset for a half cycle mid-frame with no clock edge:
  - out_valid and out_window are 0 immediately;
  - after release, a 4×4 ramp without in_sof reproduces the results of scenario 1.
- Back-to-back frames: send two ramps contiguously with in_sof on each first pixel:
  - the second frame's windows and the out_valid count match the first frame's exactly.

Source files
------------

// File: rtl/sliding_window_buffer.sv
// sliding_window_buffer: KERNELxKERNEL raster window over KERNEL-1 line buffers; WINDOW_ZERO_PAD_EN selects zero-padded edge windows.
module sliding_window_buffer #(
  parameter int PIXEL_WIDTH = 8,
  parameter int FRAME_WIDTH = 550,
  parameter int KERNEL      = 3,
  parameter int COORD_WIDTH = 16
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 in_valid_i,
  input  logic                                 in_sof_i,
  input  logic [PIXEL_WIDTH-1:0]               in_data_i,
  output logic                                 out_valid_o,
  output logic [KERNEL*KERNEL*PIXEL_WIDTH-1:0] out_window_o,
  output logic [COORD_WIDTH-1:0]               out_row_o,
  output logic [COORD_WIDTH-1:0]               out_col_o,
  output logic                                 out_sof_o,
  output logic                                 out_eol_o
);
  localparam int CW = FRAME_WIDTH > 1 ? $clog2(FRAME_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_WIDTH - 1);
  logic [CW-1:0] col_q, col_d, c_cur;
  logic [COORD_WIDTH-1:0] row_q, row_d, r_cur;
  logic [PIXEL_WIDTH-1:0] lb_q [KERNEL-1][FRAME_WIDTH];
  logic [PIXEL_WIDTH-1:0] win_q [KERNEL][KERNEL];
  logic [PIXEL_WIDTH-1:0] win_d [KERNEL][KERNEL];
  logic [PIXEL_WIDTH-1:0] tap [KERNEL];
  logic [KERNEL*KERNEL*PIXEL_WIDTH-1:0] window_d, out_window_q;
  logic [COORD_WIDTH-1:0] out_row_q, out_col_q;
  logic valid_d, out_valid_q, out_sof_q, out_eol_q;
  assign c_cur = in_sof_i ? '0 : col_q;
  assign r_cur = in_sof_i ? '0 : row_q;
  assign col_d = c_cur == LAST ? '0 : c_cur + 1'b1;
  assign row_d = (c_cur != LAST || &r_cur) ? r_cur : r_cur + 1'b1;
  // Line buffers are addressed by column, so row r-1-b of the current frame sits at lb_q[b][col].
  assign tap[KERNEL-1] = in_data_i;
  for (genvar b = 0; b < KERNEL - 1; b++) begin : g_tap
    assign tap[KERNEL-2-b] = lb_q[b][c_cur];
  end
  for (genvar r = 0; r < KERNEL; r++) begin : g_row
    for (genvar c = 0; c < KERNEL; c++) begin : g_col
      if (c == KERNEL - 1) begin : g_new
        assign win_d[r][c] = tap[r];
      end else begin : g_shift
        assign win_d[r][c] = win_q[r][c+1];
      end
`ifdef WINDOW_ZERO_PAD_EN
      localparam logic [COORD_WIDTH-1:0] DR = COORD_WIDTH'(KERNEL - 1 - r);
      localparam logic [CW-1:0] DC = CW'(KERNEL - 1 - c);
      assign window_d[(r*KERNEL+c)*PIXEL_WIDTH +: PIXEL_WIDTH] = (DR > r_cur || DC > c_cur) ? '0 : win_d[r][c];
`else
      assign window_d[(r*KERNEL+c)*PIXEL_WIDTH +: PIXEL_WIDTH] = win_d[r][c];
`endif
    end
  end
`ifdef WINDOW_ZERO_PAD_EN
  assign valid_d = 1'b1;
`else
  assign valid_d = r_cur >= COORD_WIDTH'(KERNEL - 1) && c_cur >= CW'(KERNEL - 1);
`endif
  always_ff @(posedge clk_i) begin
    if (in_valid_i) begin
      for (int b = 0; b < KERNEL - 1; b++) lb_q[b][c_cur] <= tap[KERNEL-1-b];
      win_q <= win_d;
    end
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      out_window_q <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      out_sof_q    <= 1'b0;
      out_eol_q    <= 1'b0;
    end else if (in_valid_i) begin
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= valid_d;
      out_window_q <= window_d;
      out_row_q    <= r_cur;
      out_col_q    <= COORD_WIDTH'(c_cur);
      out_sof_q    <= r_cur == '0 && c_cur == '0;
      out_eol_q    <= c_cur == LAST;
    end else begin
      out_valid_q  <= 1'b0;
    end
  end
  assign out_valid_o  = out_valid_q;
  assign out_window_o = out_window_q;
  assign out_row_o    = out_row_q;
  assign out_col_o    = out_col_q;
  assign out_sof_o    = out_sof_q;
  assign out_eol_o    = out_eol_q;
endmodule

// File: tb/tb_sliding_window_buffer.sv
// tb_sliding_window_buffer: directed and random raster streams checked against a coordinate-based frame model.
module tb_sliding_window_buffer;
  logic clk = 1'b0, reset, in_valid, in_sof;
  logic [7:0] in_data;
  logic out_valid, out_sof, out_eol;
  logic [71:0] out_window;
  logic [15:0] out_row, out_col;
`ifdef WINDOW_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam int NV = PAD ? 16 : 4;
  localparam logic [71:0] W_FIRST = 72'h0b0a09070605030201;
  localparam logic [71:0] W_LAST  = 72'h100f0e0c0b0a080706;
  always #5 clk = ~clk;
  sliding_window_buffer #(.PIXEL_WIDTH(8), .FRAME_WIDTH(4), .KERNEL(3), .COORD_WIDTH(16)) dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_sof_i(in_sof), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_window_o(out_window), .out_row_o(out_row), .out_col_o(out_col),
    .out_sof_o(out_sof), .out_eol_o(out_eol));
  int checks = 0, errors = 0, vcnt = 0;
  int mr = 0, mc = 0, er = 0, ec = 0;
  int img [8][4];
  logic [71:0] ew = '0, first_w, last_w, w5;
  bit es, ee, ew_known = 1'b1;
  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    mr = 0; mc = 0; er = 0; ec = 0; ew = '0; ew_known = 1'b1;
  endtask
  task automatic step(input bit v, input bit s, input logic [7:0] d);
    bit ev;
    int r, c, dr, dc;
    in_valid = v; in_sof = s; in_data = d; ev = 1'b0;
    if (v) begin
      r = s ? 0 : mr;
      c = s ? 0 : mc;
      img[r%8][c] = int'(d);
      ev = PAD || (r >= 2 && c >= 2);
      for (int rr = 0; rr < 3; rr++)
        for (int cc = 0; cc < 3; cc++) begin
          dr = r - 2 + rr;
          dc = c - 2 + cc;
          ew[(rr*3+cc)*8 +: 8] = (dr < 0 || dc < 0) ? 8'd0 : 8'(img[dr%8][dc]);
        end
      ew_known = ev; er = r; ec = c; es = (r == 0 && c == 0); ee = (c == 3);
      if (c == 3) begin mc = 0; mr = r + 1; end else begin mc = c + 1; mr = r; end
    end
    @(posedge clk); #1;
    chk("valid", {71'd0, out_valid}, {71'd0, ev});
    if (out_valid) begin
      vcnt++;
      if (vcnt == 1) first_w = out_window;
      if (vcnt == 5) w5 = out_window;
      last_w = out_window;
    end
    if (ev) begin
      chk("window", out_window, ew);
      chk("row", {56'd0, out_row}, 72'(er));
      chk("col", {56'd0, out_col}, 72'(ec));
      chk("sof", {71'd0, out_sof}, {71'd0, es});
      chk("eol", {71'd0, out_eol}, {71'd0, ee});
    end else if (!v) begin
      chk("hold_row", {56'd0, out_row}, 72'(er));
      chk("hold_col", {56'd0, out_col}, 72'(ec));
      if (ew_known) chk("hold_window", out_window, ew);
    end
  endtask
  task automatic ramp(input bit sof, input int gap, input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, sof && i == 0, 8'(i + 1));
      repeat (gap) step(1'b0, 1'b0, 8'd0);
    end
  endtask
  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    #12 reset = 1'b0;
    #3;
    chk("rst_valid", {71'd0, out_valid}, 72'd0);
    chk("rst_window", out_window, 72'd0);
    chk("rst_rowcol", {40'd0, out_row, out_col}, 72'd0);
    chk("rst_flags", {70'd0, out_sof, out_eol}, 72'd0);
    model_reset();
    vcnt = 0; ramp(1'b1, 0, 16);
    chk("s1_count", 72'(vcnt), 72'(NV));
    chk("s1_last", last_w, W_LAST);
`ifdef WINDOW_ZERO_PAD_EN
    chk("s1_first", first_w, 72'h010000000000000000);
    chk("s1_anchor10", w5, 72'h050000010000000000);
`else
    chk("s1_first", first_w, W_FIRST);
`endif
    vcnt = 0; ramp(1'b1, 3, 16);
    chk("stall_count", 72'(vcnt), 72'(NV));
    chk("stall_last", last_w, W_LAST);
`ifndef WINDOW_ZERO_PAD_EN
    chk("stall_first", first_w, W_FIRST);
`endif
    ramp(1'b1, 0, 6);
    step(1'b1, 1'b1, 8'd100);
    chk("restart_rowcol", {40'd0, out_row, out_col}, 72'd0);
    chk("restart_sof", {71'd0, out_sof}, 72'd1);
`ifdef WINDOW_ZERO_PAD_EN
    chk("restart_window", out_window, {8'd100, 64'd0});
`endif
    step(1'b1, 1'b0, 8'd101);
    step(1'b1, 1'b0, 8'd102);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", {71'd0, out_valid}, 72'd0);
    chk("arst_window", out_window, 72'd0);
    #1 reset = 1'b0;
    model_reset();
    vcnt = 0; ramp(1'b0, 0, 16);
    chk("arst_count", 72'(vcnt), 72'(NV));
    chk("arst_last", last_w, W_LAST);
`ifndef WINDOW_ZERO_PAD_EN
    chk("arst_first", first_w, W_FIRST);
`endif
    vcnt = 0; ramp(1'b1, 0, 16);
    chk("b2b_count1", 72'(vcnt), 72'(NV));
    vcnt = 0; ramp(1'b1, 0, 16);
    chk("b2b_count2", 72'(vcnt), 72'(NV));
    chk("b2b_last", last_w, W_LAST);
`ifndef WINDOW_ZERO_PAD_EN
    chk("b2b_first", first_w, W_FIRST);
`endif
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 8'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
